msg_scroll_display: RTL and testbench

- Parametrised multiplexed 7-segment message driver; next generation of the fixed "Error" display.
- Holds a loadable message of up to MSG_LEN characters, written through a valid/ready handshake into a shadow buffer and committed atomically.
- Drives NUM_DIGITS common-anode digits (active-low segments and anodes) in static, scrolling or blinking mode.
- Sits between the animation/control FSM and the board display pins.

---
 rtl/msg_scroll_display.sv | 177 +++++++++++++++++
 tb/tb_msg_scroll_display.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/msg_scroll_display.sv
// Multiplexed 7-segment message driver: shadow-buffered message load, static/scroll/blink modes.
// Optional DISP_DIM_EN adds a brillo input that shortens the per-slot anode on-time.
module msg_scroll_display #(
    parameter int NUM_DIGITS    = 8,
    parameter int MSG_LEN       = 16,
    parameter int REFRESH_DIV   = 100000,
    parameter int SCROLL_FRAMES = 50,
    parameter int BLINK_FRAMES  = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            modo,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4:0]            wr_char,
    input  logic                  wr_last,
`ifdef DISP_DIM_EN
    input  logic [3:0]            brillo,
`endif
    output logic [6:0]            segmentos,
    output logic [NUM_DIGITS-1:0] anodos
);
    localparam int LW = $clog2(MSG_LEN + 1);
    localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int PW = $clog2(MSG_LEN + 2 * NUM_DIGITS);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(SCROLL_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [4:0]      shadow [MSG_LEN];
    logic [4:0]      active [MSG_LEN];
    logic [LW-1:0]   wptr, act_len;
    logic            commit;
    logic [1:0]      modo_q;
    logic [RW-1:0]   ref_cnt;
    logic [DW-1:0]   dig_idx;
    logic [SW-1:0]   sc_cnt;
    logic [BW-1:0]   bl_cnt;
    logic [PW-1:0]   offset;
    logic            blink_hidden;

    logic            slot_end, frame_end, mode_chg, dim_on;
    logic [PW-1:0]   v_len, p_raw, p;
    logic [4:0]      ch;
    logic [NUM_DIGITS-1:0] an_sel;

    function automatic logic [6:0] decode(input logic [4:0] c);
        case (c)
            5'h00: decode = 7'h40;  5'h01: decode = 7'h79;
            5'h02: decode = 7'h24;  5'h03: decode = 7'h30;
            5'h04: decode = 7'h19;  5'h05: decode = 7'h12;
            5'h06: decode = 7'h02;  5'h07: decode = 7'h78;
            5'h08: decode = 7'h00;  5'h09: decode = 7'h10;
            5'h0A: decode = 7'h08;  5'h0B: decode = 7'h03;
            5'h0C: decode = 7'h46;  5'h0D: decode = 7'h21;
            5'h0E: decode = 7'h06;  5'h0F: decode = 7'h0E;
            5'h11: decode = 7'h2F;  5'h12: decode = 7'h40;
            5'h13: decode = 7'h3F;  5'h14: decode = 7'h09;
            5'h15: decode = 7'h47;  5'h16: decode = 7'h0C;
            5'h17: decode = 7'h41;
            default: decode = 7'h7F;
        endcase
    endfunction

    // The commit cycle is the only cycle the shadow buffer is busy.
    assign wr_ready  = !rst && !commit;
    assign slot_end  = (ref_cnt == RW'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (dig_idx == DW'(NUM_DIGITS - 1));
    assign mode_chg  = (modo != modo_q);

`ifdef DISP_DIM_EN
    logic [3:0] brillo_s;
    assign dim_on = 32'(ref_cnt) < (((32'(brillo_s) + 32'd1) * 32'(REFRESH_DIV)) >> 4);
`else
    assign dim_on = 1'b1;
`endif

    // Scroll position wraps with a single compare-subtract: offset < V and d < NUM_DIGITS <= V.
    always_comb begin
        v_len = PW'(act_len) + PW'(NUM_DIGITS);
        p_raw = PW'(dig_idx);
        if (modo == 2'd1)
            p_raw = offset + PW'(dig_idx);
        p  = (p_raw >= v_len) ? p_raw - v_len : p_raw;
        ch = (p < PW'(act_len)) ? active[IW'(p)] : 5'h10;
        an_sel = '1;
        an_sel[DW'(NUM_DIGITS - 1) - dig_idx] = !dim_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            act_len      <= '0;
            commit       <= 1'b0;
            modo_q       <= 2'd0;
            ref_cnt      <= '0;
            dig_idx      <= '0;
            sc_cnt       <= '0;
            bl_cnt       <= '0;
            offset       <= '0;
            blink_hidden <= 1'b0;
            segmentos    <= 7'h7F;
            anodos       <= '1;
`ifdef DISP_DIM_EN
            brillo_s     <= 4'hF;
`endif
        end else begin
            modo_q <= modo;
            if (commit) begin
                active  <= shadow;
                act_len <= wptr;
                wptr    <= '0;
                commit  <= 1'b0;
            end else if (wr_valid) begin
                if (wptr != LW'(MSG_LEN)) begin
                    shadow[IW'(wptr)] <= wr_char;
                    wptr              <= wptr + 1'b1;
                end
                if (wr_last)
                    commit <= 1'b1;
            end

            if (!enable) begin
                ref_cnt      <= '0;
                dig_idx      <= '0;
                sc_cnt       <= '0;
                bl_cnt       <= '0;
                offset       <= '0;
                blink_hidden <= 1'b0;
                segmentos    <= 7'h7F;
                anodos       <= '1;
`ifdef DISP_DIM_EN
                brillo_s     <= brillo;
`endif
            end else begin
                ref_cnt <= slot_end ? '0 : ref_cnt + 1'b1;
                if (slot_end) begin
                    dig_idx <= (dig_idx == DW'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
`ifdef DISP_DIM_EN
                    brillo_s <= brillo;
`endif
                end
                if (mode_chg) begin
                    sc_cnt       <= '0;
                    bl_cnt       <= '0;
                    offset       <= '0;
                    blink_hidden <= 1'b0;
                end else if (commit) begin
                    offset       <= '0;
                    blink_hidden <= 1'b0;
                end else if (frame_end) begin
                    if (sc_cnt == SW'(SCROLL_FRAMES - 1)) begin
                        sc_cnt <= '0;
                        offset <= (offset == v_len - 1'b1) ? '0 : offset + 1'b1;
                    end else begin
                        sc_cnt <= sc_cnt + 1'b1;
                    end
                    if (bl_cnt == BW'(BLINK_FRAMES - 1)) begin
                        bl_cnt       <= '0;
                        blink_hidden <= !blink_hidden;
                    end else begin
                        bl_cnt <= bl_cnt + 1'b1;
                    end
                end
                if (modo == 2'd2 && blink_hidden) begin
                    segmentos <= 7'h7F;
                    anodos    <= '1;
                end else begin
                    segmentos <= decode(ch);
                    anodos    <= an_sel;
                end
            end
        end
    end
endmodule

// File: tb/tb_msg_scroll_display.sv
// Directed bench for msg_scroll_display: checkpoint tables per scenario plus handshake/reset sequences.
module tb_msg_scroll_display;
    localparam int ND = 4, ML = 8, RD = 4, SF = 2, BF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1, enable = 1'b0, wr_valid = 1'b0, wr_last = 1'b0;
    logic [1:0] modo = 2'd0;
    logic [4:0] wr_char = 5'd0;
    logic wr_ready;
    logic [6:0] segmentos;
    logic [ND-1:0] anodos;
`ifdef DISP_DIM_EN
    logic [3:0] brillo = 4'hF;
`endif

    msg_scroll_display #(.NUM_DIGITS(ND), .MSG_LEN(ML), .REFRESH_DIV(RD),
                         .SCROLL_FRAMES(SF), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .enable(enable), .modo(modo),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_char(wr_char), .wr_last(wr_last),
`ifdef DISP_DIM_EN
        .brillo(brillo),
`endif
        .segmentos(segmentos), .anodos(anodos));

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        bit         use_an;
        string      nm;
    } vec_t;

    vec_t vq[$];
    int total = 0, bad = 0, cyc = 0;
    logic [6:0] hexseg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic step();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic addv(input int k, input logic [3:0] an, input logic [6:0] seg,
                        input bit use_an, input string nm);
        vec_t v;
        v.k = k; v.an = an; v.seg = seg; v.use_an = use_an; v.nm = nm;
        vq.push_back(v);
    endtask

    // Checkpoint k = k-th clock edge after the display was enabled.
    task automatic run_vecs();
        foreach (vq[i]) begin
            if (cyc > vq[i].k) begin
                total++; bad++;
                $display("FAIL %s: checkpoint %0d already passed at cyc %0d", vq[i].nm, vq[i].k, cyc);
            end else begin
                while (cyc < vq[i].k) step();
                if (vq[i].use_an) chk({vq[i].nm, "_an"}, 32'(anodos), 32'(vq[i].an));
                chk({vq[i].nm, "_seg"}, 32'(segmentos), 32'(vq[i].seg));
            end
        end
        vq.delete();
    endtask

    task automatic put(input logic [4:0] c, input logic last);
        wr_valid = 1'b1; wr_char = c; wr_last = last;
        chk("wr_ready_hi", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0; wr_last = 1'b0;
        if (last) begin
            chk("wr_ready_commit", 32'(wr_ready), 32'd0);
            step();
            chk("wr_ready_after", 32'(wr_ready), 32'd1);
        end
    endtask

    task automatic idle();
        enable = 1'b0;
        step();
    endtask

    task automatic go(input logic [1:0] m);
        enable = 1'b0; modo = m;
        step(); step();
        enable = 1'b1;
        cyc = 0;
    endtask

    initial begin
        step(); step();
        chk("rst_an", 32'(anodos), 32'hF);
        chk("rst_seg", 32'(segmentos), 32'h7F);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("ready_out_of_rst", 32'(wr_ready), 32'd1);

        // "Error" static
        put(5'h0E, 0); put(5'h11, 0); put(5'h11, 0); put(5'h12, 0); put(5'h11, 1);
        go(2'd0);
        addv(1, 4'b0111, 7'h06, 1, "st_d0");   addv(4, 4'b0111, 7'h06, 1, "st_d0_end");
        addv(5, 4'b1011, 7'h2F, 1, "st_d1");   addv(9, 4'b1101, 7'h2F, 1, "st_d2");
        addv(13, 4'b1110, 7'h40, 1, "st_d3");  addv(16, 4'b1110, 7'h40, 1, "st_d3_end");
        addv(17, 4'b0111, 7'h06, 1, "st_rep0"); addv(21, 4'b1011, 7'h2F, 1, "st_rep1");
        addv(29, 4'b1110, 7'h40, 1, "st_rep3");
        run_vecs();
        idle();
        chk("en_low_an", 32'(anodos), 32'hF);
        chk("en_low_seg", 32'(segmentos), 32'h7F);

`ifdef DISP_DIM_EN
        begin
            int lowc;
            brillo = 4'd7;
            go(2'd0);
            lowc = 0;
            repeat (16) begin step(); if (anodos != 4'hF) lowc++; end
            chk("dim7_on_cycles", 32'(lowc), 32'd8);
            brillo = 4'd15;
            go(2'd0);
            lowc = 0;
            repeat (16) begin step(); if (anodos != 4'hF) lowc++; end
            chk("dim15_on_cycles", 32'(lowc), 32'd16);
        end
`endif

        // 10 chars into an 8-deep buffer: 8 and 9 must be dropped
        idle();
        for (int i = 0; i < 10; i++) put(5'(i), i == 9);
        go(2'd1);
        for (int o = 0; o <= 12; o++)
            addv(32 * o + 1, 4'b0111, (o < 8) ? hexseg[o] : ((o < 12) ? 7'h7F : hexseg[0]), 1, "sat_d0");
        vq.insert(10, '{k: 301, an: 4'b1110, seg: hexseg[0], use_an: 1'b1, nm: "sat_d3_wrap"});
        run_vecs();

        // "12" scrolling, V = 6
        idle();
        put(5'h01, 0); put(5'h02, 1);
        go(2'd1);
        addv(1, 4'b0111, 7'h79, 1, "sc_o0");    addv(5, 4'b1011, 7'h24, 1, "sc_o0_d1");
        addv(33, 4'b0111, 7'h24, 1, "sc_o1");   addv(65, 4'b0111, 7'h7F, 1, "sc_o2");
        addv(97, 4'b0111, 7'h7F, 1, "sc_o3");   addv(129, 4'b0111, 7'h7F, 1, "sc_o4");
        addv(161, 4'b0111, 7'h7F, 1, "sc_o5");  addv(165, 4'b1011, 7'h79, 1, "sc_o5_d1");
        addv(193, 4'b0111, 7'h79, 1, "sc_wrap");
        run_vecs();

        // commit "3" while scrolling "12" at offset 1
        go(2'd1);
        addv(33, 4'b0111, 7'h24, 1, "mid_old");
        run_vecs();
        put(5'h03, 1);
        addv(35, 4'b0111, 7'h24, 1, "mid_pre_commit"); addv(36, 4'b0111, 7'h30, 1, "mid_new");
        addv(37, 4'b1011, 7'h7F, 1, "mid_new_d1");     addv(109, 4'b1110, 7'h30, 1, "mid_v5");
        run_vecs();

        // "HELP" blinking, then back to static while hidden
        idle();
        put(5'h14, 0); put(5'h0E, 0); put(5'h15, 0); put(5'h16, 1);
        go(2'd2);
        addv(1, 4'b0111, 7'h09, 1, "bl_h");     addv(5, 4'b1011, 7'h06, 1, "bl_e");
        addv(9, 4'b1101, 7'h47, 1, "bl_l");     addv(13, 4'b1110, 7'h0C, 1, "bl_p");
        addv(32, 4'b1110, 7'h0C, 1, "bl_vis_end"); addv(33, 4'b1111, 7'h7F, 1, "bl_hid");
        addv(64, 4'b1111, 7'h7F, 1, "bl_hid_end"); addv(65, 4'b0111, 7'h09, 1, "bl_vis2");
        addv(100, 4'b1111, 7'h7F, 1, "bl_hid2");
        run_vecs();
        modo = 2'd0;
        addv(101, 4'b1011, 7'h06, 1, "bl_to_static"); addv(140, 4'b1101, 7'h47, 1, "bl_static_l");
        run_vecs();

        // reset in the middle of a write
        wr_valid = 1'b1; wr_char = 5'h05; wr_last = 1'b0;
        step();
        wr_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rst_mid_ready", 32'(wr_ready), 32'd0);
        step();
        chk("rst_mid_an", 32'(anodos), 32'hF);
        chk("rst_mid_seg", 32'(segmentos), 32'h7F);
        rst = 1'b0;
        go(2'd0);
        addv(1, 4'b0000, 7'h7F, 0, "len0_d0"); addv(5, 4'b0000, 7'h7F, 0, "len0_d1");
        addv(13, 4'b0000, 7'h7F, 0, "len0_d3");
        run_vecs();
        idle();
        put(5'h07, 1);
        go(2'd0);
        addv(1, 4'b0111, 7'h78, 1, "wptr0_d0"); addv(5, 4'b1011, 7'h7F, 1, "wptr0_d1");
        run_vecs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
